// File: rtl/llfifo_pkg.sv
// Shared types for the linked-list FIFO block: queue id / slot pointer widths,
// scheduler FSM states and the grant record passed between decision and issue.
package llfifo_pkg;
  localparam int ID_N  = 4;
  localparam int PTR_N = 8;
  localparam int ID_W  = (ID_N  > 1) ? $clog2(ID_N)  : 1;
  localparam int PTR_W = (PTR_N > 1) ? $clog2(PTR_N) : 1;

  typedef logic [ID_W-1:0]  id_t;
  typedef logic [PTR_W-1:0] ptr_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} sched_state_t;

  typedef enum logic [1:0] {G_NONE, G_CLEAR, G_PUSH, G_POP} grant_kind_t;

  typedef struct packed {
    grant_kind_t kind;
    id_t         id;
  } grant_t;
endpackage

// File: rtl/llfifo_rr_pick.sv
// Round-robin picker: first set request bit strictly after 'last', wrapping.
module llfifo_rr_pick
  import llfifo_pkg::*;
#(
  parameter int ID_N = llfifo_pkg::ID_N
) (
  input  logic [ID_N-1:0] req,
  input  id_t             last,
  output id_t             gnt,
  output logic            any
);

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    int k;
    k   = 0;
    gnt = '0;
    any = 1'b0;
    for (int i = ID_N; i >= 1; i--) begin
      k = (int'(last) + i) % ID_N;
      if (req[k]) begin
        gnt = id_t'(k);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/llfifo_sched.sv
// Push/pop/clear command scheduler in front of the linked-list FIFO controller.
// One command per IDLE->ISSUE->WAIT round; the controller status is trusted only in IDLE.
module llfifo_sched
  import llfifo_pkg::*;
#(
  parameter int ID_N = llfifo_pkg::ID_N
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push_vld,
  input  id_t             push_id,
  output logic            push_rdy,
  output ptr_t            push_ptr,
  input  logic [ID_N-1:0] pop_en,
  output logic            pop_vld,
  output id_t             pop_id,
  output ptr_t            pop_ptr,
  input  logic            clear_req,
  output logic            clear_ack,
  output logic            cmd_pass,
  output logic            cmd_push,
  output id_t             cmd_id,
  output logic            clear,
  input  ptr_t            cmd_push_ptr_r,
  input  ptr_t            cmd_pop_ptr_w,
  input  logic            busy_r,
  input  logic            full_r,
  input  logic            empty_r,
  input  logic [ID_N-1:0] nempty_r
);

  sched_state_t state;
  id_t          rr_ptr;
  logic         last_was_push;
  logic         clear_pend;
  grant_kind_t  g_kind;

  logic [ID_N-1:0] pop_req;
  id_t             pick_id;
  logic            pop_ok;
  logic            push_ok;
  grant_t          nxt;
  logic            unused_status;

  assign unused_status = empty_r;
  assign pop_req       = nempty_r & pop_en;
  assign push_ok       = push_vld && !full_r;

  llfifo_rr_pick #(.ID_N(ID_N)) u_pick (
    .req  (pop_req),
    .last (rr_ptr),
    .gnt  (pick_id),
    .any  (pop_ok)
  );

  // Clear beats everything; push and pop take turns when both are eligible.
  always_comb begin
    nxt.kind = G_NONE;
    nxt.id   = '0;
    if (clear_req || clear_pend) begin
      nxt.kind = G_CLEAR;
    end else if (push_ok && (!pop_ok || !last_was_push)) begin
      nxt.kind = G_PUSH;
      nxt.id   = push_id;
    end else if (pop_ok) begin
      nxt.kind = G_POP;
      nxt.id   = pick_id;
    end
  end

  // The controller returns the alloc pointer combinationally for cmd_id.
  assign push_ptr = push_rdy ? cmd_push_ptr_r : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      rr_ptr        <= id_t'(ID_N - 1);
      last_was_push <= 1'b0;
      clear_pend    <= 1'b0;
      g_kind        <= G_NONE;
      cmd_pass      <= 1'b0;
      cmd_push      <= 1'b0;
      cmd_id        <= '0;
      clear         <= 1'b0;
      clear_ack     <= 1'b0;
      push_rdy      <= 1'b0;
      pop_vld       <= 1'b0;
      pop_id        <= '0;
      pop_ptr       <= '0;
    end else begin
      cmd_pass   <= 1'b0;
      cmd_push   <= 1'b0;
      clear      <= 1'b0;
      clear_ack  <= 1'b0;
      push_rdy   <= 1'b0;
      pop_vld    <= 1'b0;
      pop_id     <= '0;
      clear_pend <= clear_pend | clear_req;
      case (state)
        S_IDLE: begin
          if (!busy_r && nxt.kind != G_NONE) begin
            state  <= S_ISSUE;
            g_kind <= nxt.kind;
            case (nxt.kind)
              G_CLEAR: begin
                clear      <= 1'b1;
                clear_ack  <= 1'b1;
                clear_pend <= 1'b0;
              end
              G_PUSH: begin
                cmd_pass      <= 1'b1;
                cmd_push      <= 1'b1;
                cmd_id        <= nxt.id;
                push_rdy      <= 1'b1;
                last_was_push <= 1'b1;
              end
              default: begin
                cmd_pass      <= 1'b1;
                cmd_id        <= nxt.id;
                rr_ptr        <= nxt.id;
                last_was_push <= 1'b0;
              end
            endcase
          end
        end
        S_ISSUE: begin
          state <= S_WAIT;
          if (g_kind == G_POP) begin
            pop_vld <= 1'b1;
            pop_id  <= cmd_id;
            pop_ptr <= cmd_pop_ptr_w;
          end
        end
        default: begin
          if (!busy_r) state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_llfifo_sched.sv
// Directed scenarios plus random traffic, every cycle compared against a
// transaction-level model of the scheduling rules.
module tb_llfifo_sched;
  import llfifo_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, push_vld, clear_req, busy_r, full_r, empty_r;
  id_t          push_id;
  logic [N-1:0] pop_en, nempty_r;
  ptr_t         cmd_push_ptr_r, cmd_pop_ptr_w;
  logic         push_rdy, pop_vld, clear_ack, cmd_pass, cmd_push, clear;
  ptr_t         push_ptr, pop_ptr;
  id_t          pop_id, cmd_id;

  llfifo_sched #(.ID_N(N)) dut (
    .clk(clk), .rst(rst),
    .push_vld(push_vld), .push_id(push_id), .push_rdy(push_rdy), .push_ptr(push_ptr),
    .pop_en(pop_en), .pop_vld(pop_vld), .pop_id(pop_id), .pop_ptr(pop_ptr),
    .clear_req(clear_req), .clear_ack(clear_ack),
    .cmd_pass(cmd_pass), .cmd_push(cmd_push), .cmd_id(cmd_id), .clear(clear),
    .cmd_push_ptr_r(cmd_push_ptr_r), .cmd_pop_ptr_w(cmd_pop_ptr_w),
    .busy_r(busy_r), .full_r(full_r), .empty_r(empty_r), .nempty_r(nempty_r)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: 'ready' means a decision may be taken now; 'since' counts cycles of
  // the current command round (1 = command on the bus, 2+ = waiting on busy).
  bit   m_ready, m_last_push, m_pend, m_popped;
  int   m_since, m_rr;
  logic e_cmd_pass, e_cmd_push, e_clear, e_ack, e_push_rdy, e_pop_vld;
  int   e_cmd_id, e_pop_id, e_pop_ptr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int  pick;
    bit  want_clear, can_push;
    e_cmd_pass = 0; e_cmd_push = 0; e_clear = 0; e_ack = 0;
    e_push_rdy = 0; e_pop_vld = 0;  e_pop_id = 0;
    if (rst) begin
      m_ready = 1; m_since = 0; m_rr = N - 1; m_last_push = 0; m_pend = 0; m_popped = 0;
      e_cmd_id = 0; e_pop_ptr = 0;
      return;
    end
    want_clear = clear_req || m_pend;
    m_pend     = m_pend || clear_req;
    if (m_ready) begin
      if (!busy_r) begin
        pick = -1;
        for (int i = N; i >= 1; i--)
          if (nempty_r[(m_rr + i) % N] && pop_en[(m_rr + i) % N]) pick = (m_rr + i) % N;
        can_push = push_vld && !full_r;
        if (want_clear) begin
          e_clear = 1; e_ack = 1; m_pend = 0; m_popped = 0;
          m_ready = 0; m_since = 1;
        end else if (can_push && (pick < 0 || !m_last_push)) begin
          e_cmd_pass = 1; e_cmd_push = 1; e_cmd_id = push_id; e_push_rdy = 1;
          m_last_push = 1; m_popped = 0; m_ready = 0; m_since = 1;
        end else if (pick >= 0) begin
          e_cmd_pass = 1; e_cmd_id = pick; m_rr = pick;
          m_last_push = 0; m_popped = 1; m_ready = 0; m_since = 1;
        end
      end
    end else if (m_since == 1) begin
      m_since = 2;
      if (m_popped) begin
        e_pop_vld = 1; e_pop_id = e_cmd_id; e_pop_ptr = cmd_pop_ptr_w;
      end
    end else if (!busy_r) begin
      m_ready = 1;
    end
  endtask

  task automatic check_outputs();
    chk("cmd_pass",  32'(cmd_pass),  32'(e_cmd_pass));
    chk("cmd_push",  32'(cmd_push),  32'(e_cmd_push));
    chk("clear",     32'(clear),     32'(e_clear));
    chk("clear_ack", 32'(clear_ack), 32'(e_ack));
    chk("push_rdy",  32'(push_rdy),  32'(e_push_rdy));
    chk("push_ptr",  32'(push_ptr),  e_push_rdy ? 32'(cmd_push_ptr_r) : 32'd0);
    chk("pop_vld",   32'(pop_vld),   32'(e_pop_vld));
    chk("pop_id",    32'(pop_id),    32'(e_pop_id));
    chk("pop_ptr",   32'(pop_ptr),   32'(e_pop_ptr));
    chk("cmd_id",    32'(cmd_id),    32'(e_cmd_id));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic quiet_inputs();
    push_vld = 0; push_id = '0; clear_req = 0; busy_r = 0; full_r = 0; empty_r = 1;
    pop_en = '0; nempty_r = '0; cmd_push_ptr_r = '0; cmd_pop_ptr_w = '0;
  endtask

  task automatic do_reset();
    rst = 1; quiet_inputs();
    cyc(); cyc();
    rst = 0;
  endtask

  initial begin
    int ids[$];
    int at[$];
    int cnt_pass, cnt_rdy;

    rst = 1; quiet_inputs();
    do_reset();

    // Reset state, explicit constants.
    chk("rst_cmd_pass", 32'(cmd_pass), 32'd0);
    chk("rst_pop_vld",  32'(pop_vld),  32'd0);
    chk("rst_cmd_id",   32'(cmd_id),   32'd0);
    chk("rst_pop_ptr",  32'(pop_ptr),  32'd0);

    // First push straight after reset.
    push_vld = 1; push_id = id_t'(2); cmd_push_ptr_r = ptr_t'(5); cmd_pop_ptr_w = ptr_t'(6);
    cyc();
    chk("push_cmd_pass", 32'(cmd_pass), 32'd1);
    chk("push_cmd_push", 32'(cmd_push), 32'd1);
    chk("push_cmd_id",   32'(cmd_id),   32'd2);
    chk("push_rdy",      32'(push_rdy), 32'd1);
    chk("push_ptr_val",  32'(push_ptr), 32'd5);
    push_vld = 0;
    cyc(); cyc();

    // Round-robin pop order and command spacing.
    do_reset();
    nempty_r = 4'b1011; pop_en = 4'b1111;
    for (int c = 0; c < 13; c++) begin
      cyc();
      if (cmd_pass) begin ids.push_back(int'(cmd_id)); at.push_back(c); end
    end
    chk("rr_grants", 32'(ids.size()), 32'd5);
    if (ids.size() >= 4) begin
      chk("rr_id0", 32'(ids[0]), 32'd0);
      chk("rr_id1", 32'(ids[1]), 32'd1);
      chk("rr_id2", 32'(ids[2]), 32'd3);
      chk("rr_id3", 32'(ids[3]), 32'd0);
      chk("rr_gap", 32'(at[1] - at[0]), 32'd3);
    end

    // Push/pop alternation.
    do_reset();
    ids.delete();
    push_vld = 1; push_id = id_t'(1); nempty_r = 4'b0001; pop_en = 4'b1111;
    for (int c = 0; c < 12; c++) begin
      cyc();
      if (cmd_pass) ids.push_back(int'(cmd_push));
    end
    chk("alt_grants", 32'(ids.size()), 32'd4);
    if (ids.size() >= 4) begin
      chk("alt_0", 32'(ids[0]), 32'd1);
      chk("alt_1", 32'(ids[1]), 32'd0);
      chk("alt_2", 32'(ids[2]), 32'd1);
      chk("alt_3", 32'(ids[3]), 32'd0);
    end

    // Full controller blocks pushes.
    do_reset();
    full_r = 1; push_vld = 1; nempty_r = '0; pop_en = 4'b1111;
    cnt_pass = 0; cnt_rdy = 0;
    for (int c = 0; c < 20; c++) begin
      cyc();
      cnt_pass += int'(cmd_pass);
      cnt_rdy  += int'(push_rdy);
    end
    chk("full_no_cmd", 32'(cnt_pass), 32'd0);
    chk("full_no_rdy", 32'(cnt_rdy),  32'd0);

    // Clear arriving while a pop is in flight.
    do_reset();
    nempty_r = 4'b0001; pop_en = 4'b0001; cmd_pop_ptr_w = ptr_t'(3);
    cyc();
    chk("clr_pop_issue", 32'(cmd_pass), 32'd1);
    clear_req = 1;
    cyc();
    chk("clr_pop_vld", 32'(pop_vld), 32'd1);
    chk("clr_pop_ptr", 32'(pop_ptr), 32'd3);
    clear_req = 0;
    cyc(); cyc();
    chk("clr_clear", 32'(clear),     32'd1);
    chk("clr_ack",   32'(clear_ack), 32'd1);
    chk("clr_pass",  32'(cmd_pass),  32'd0);
    cyc(); cyc();

    // Reset in the middle of an ISSUE cycle.
    do_reset();
    push_vld = 1; push_id = id_t'(3); nempty_r = '0;
    cyc();
    chk("abort_issue", 32'(cmd_pass), 32'd1);
    rst = 1; push_vld = 0;
    cyc();
    chk("abort_pass",  32'(cmd_pass), 32'd0);
    chk("abort_rdy",   32'(push_rdy), 32'd0);
    chk("abort_pop",   32'(pop_vld),  32'd0);
    rst = 0; nempty_r = 4'b1111; pop_en = 4'b1111;
    cyc();
    chk("abort_rr_first", 32'(cmd_id), 32'd0);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst            = ($urandom_range(0, 199) == 0);
      push_vld       = ($urandom_range(0, 1) == 1);
      push_id        = id_t'($urandom_range(0, N - 1));
      clear_req      = ($urandom_range(0, 15) == 0);
      busy_r         = ($urandom_range(0, 2) == 0);
      full_r         = ($urandom_range(0, 3) == 0);
      empty_r        = ($urandom_range(0, 1) == 1);
      pop_en         = 4'($urandom);
      nempty_r       = 4'($urandom);
      cmd_push_ptr_r = ptr_t'($urandom);
      cmd_pop_ptr_w  = ptr_t'($urandom);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/llfifo_sched.md
LLFIFO_SCHED -- requirements
Module: llfifo_sched

Interface
REQ-001 Parameter ID_N, default llfifo_pkg::ID_N: number of queue ids arbitrated.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 push_vld  in  1  upstream push request.
REQ-005 push_id  in  id_t  target queue of push.
REQ-006 push_rdy  out  1  one-cycle pulse: push accepted; push_ptr valid this cycle.
REQ-007 push_ptr  out  ptr_t  slot allocated to accepted push.
REQ-008 pop_en  in  ID_N  per-id downstream permission to pop.
REQ-009 pop_vld  out  1  one-cycle pulse: pop completed.
REQ-010 pop_id / pop_ptr  out  id_t / ptr_t  id popped and slot freed.
REQ-011 clear_req  in  1  request to flush all queues.
REQ-012 clear_ack  out  1  one-cycle pulse when clear is issued.
REQ-013 cmd_pass / cmd_push / cmd_id  out  1 / 1 / id_t  command to FIFO controller.
REQ-014 clear  out  1  flush strobe to FIFO controller.
REQ-015 cmd_push_ptr_r / cmd_pop_ptr_w  in  ptr_t  controller alloc pointer / pop pointer for cmd_id.
REQ-016 busy_r / full_r / empty_r  in  1  controller status.
REQ-017 nempty_r  in  ID_N  per-id non-empty flags.

Function
REQ-018 FSM states IDLE, ISSUE, WAIT; IDLE->ISSUE on any grant, ISSUE->WAIT always, WAIT->IDLE when busy_r==0.
REQ-019 Grant evaluated only in IDLE with busy_r==0; status inputs are valid only then.
REQ-020 Priority in IDLE: clear_req > push/pop; clear issues in ISSUE as clear=1 for one cycle, cmd_pass=0, clear_ack=1.
REQ-021 Push eligible: push_vld && !full_r; pop eligible: any (nempty_r & pop_en) bit set.
REQ-022 Both eligible: alternate using 1-bit last_was_push flag; push wins when flag=0; flag updates on every push/pop grant.
REQ-023 Pop id chosen round-robin over (nempty_r & pop_en), search starting at rr_ptr+1 mod ID_N; rr_ptr <= granted id.
REQ-024 Grant registered; in ISSUE cmd_pass=1, cmd_push, cmd_id driven from registers for exactly one cycle.
REQ-025 Push in ISSUE: push_rdy=1, push_ptr=cmd_push_ptr_r same cycle.
REQ-026 Pop in ISSUE: capture cmd_pop_ptr_w; pop_vld=1, pop_id, pop_ptr driven the cycle after ISSUE (first WAIT cycle).
REQ-027 At most one controller command per 3 cycles; no command while busy_r=1.
REQ-028 push_vld may drop without acceptance; no push granted while full_r=1; no pop on ids with nempty_r=0 or pop_en=0.
REQ-029 clear_req arriving during ISSUE/WAIT is held pending and served at next IDLE.
REQ-030 All outputs other than push_ptr, pop_ptr, cmd_id are 0 outside their pulse cycle.

Reset
REQ-031 On rst: state=IDLE; cmd_pass, cmd_push, clear, push_rdy, pop_vld, clear_ack=0; cmd_id, pop_id, pop_ptr, push_ptr=0; rr_ptr=ID_N-1; last_was_push=0.
REQ-032 rst mid-ISSUE/WAIT aborts immediately; no pulse emitted in the following cycle.

Structure
REQ-033 id_t, ptr_t, ID_N, PTR_N reuse llfifo_pkg; sched_state_t enum added to llfifo_pkg.
REQ-034 Round-robin picker is one sub-module, llfifo_rr_pick (request vector, last index -> grant index, any).
REQ-035 Target size 120-400 lines RTL.

Verification (ID_N=4, PTR_N=8)
REQ-036 After reset, push_vld=1 id=2, controller idle -> ISSUE at cycle 2 with cmd_pass=1, cmd_push=1, cmd_id=2, push_rdy=1, push_ptr=cmd_push_ptr_r.
REQ-037 nempty_r=4'b1011, pop_en=4'b1111, no push -> pop ids granted in order 0,1,3,0; gap 3 cycles between cmd_pass pulses.
REQ-038 push_vld=1 and nempty_r=4'b0001 continuously -> grants alternate push, pop, push, pop.
REQ-039 full_r=1, push_vld=1, nempty_r=0 -> no cmd_pass for 20 cycles; push_rdy stays 0.
REQ-040 clear_req asserted during WAIT of a pop -> pop_vld pulses, then next ISSUE drives clear=1, clear_ack=1, cmd_pass=0.
REQ-041 rst asserted in ISSUE cycle -> next cycle all pulse outputs 0, state IDLE, rr_ptr=3.
